// File: rtl/condicionador_botoes.sv
// Button input stage: polarity normalise, 2-FF sync, debounce, press-edge detect, and
// merge of two near-simultaneous presses into one b1&b2 command pulse.
//
// state | meaning
// IDLE  | no pending press, waiting for a press edge
// WAIT1 | button 1 pressed, window open for button 2
// WAIT2 | button 2 pressed, window open for button 1
// LOCK  | command emitted, waiting for both buttons released
module condicionador_botoes #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int COMBO_WINDOW    = 8,
   parameter int BTN_ACTIVE_LOW  = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn1_in,
   input  logic btn2_in,
   output logic b1,
   output logic b2
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int WW = $clog2(COMBO_WINDOW) + 1;
   localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WW-1:0] WCNT_LAST = WW'(COMBO_WINDOW - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT1 = 2'd1,
      WAIT2 = 2'd2,
      LOCK  = 2'd3
   } state_t;

   // index 0 = button 1, index 1 = button 2
   logic [1:0]         meta_q, meta_d;
   logic [1:0]         sync_q, sync_d;
   logic [1:0]         deb_q, deb_d;
   logic [1:0]         deb_dly_q, deb_dly_d;
   logic [1:0][DW-1:0] dcnt_q, dcnt_d;
   logic [1:0]         press;

   state_t             state_q, state_d;
   logic [WW-1:0]      wcnt_q, wcnt_d;
   logic               b1_q, b1_d;
   logic               b2_q, b2_d;

   always_comb begin
      meta_d    = {btn2_in, btn1_in} ^ {2{BTN_ACTIVE_LOW != 0}};
      sync_d    = meta_q;
      deb_dly_d = deb_q;
      deb_d     = deb_q;
      dcnt_d    = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync_q[i] != deb_q[i]) begin
            if (dcnt_q[i] == DCNT_LAST) begin
               deb_d[i] = sync_q[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + DW'(1);
            end
         end
      end
      press = deb_q & ~deb_dly_q;
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      b1_d    = 1'b0;
      b2_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (press[0] && press[1]) begin
               b1_d    = 1'b1;
               b2_d    = 1'b1;
               state_d = LOCK;
            end else if (press[0]) begin
               state_d = WAIT1;
               wcnt_d  = '0;
            end else if (press[1]) begin
               state_d = WAIT2;
               wcnt_d  = '0;
            end
         end
         WAIT1: begin
            // the other press wins over expiry when both land in the same cycle
            if (press[1]) begin
               b1_d    = 1'b1;
               b2_d    = 1'b1;
               state_d = LOCK;
            end else if (wcnt_q == WCNT_LAST) begin
               b1_d    = 1'b1;
               state_d = LOCK;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         WAIT2: begin
            if (press[0]) begin
               b1_d    = 1'b1;
               b2_d    = 1'b1;
               state_d = LOCK;
            end else if (wcnt_q == WCNT_LAST) begin
               b2_d    = 1'b1;
               state_d = LOCK;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         LOCK: begin
            if (deb_q == 2'b00) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q    <= '0;
         sync_q    <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         dcnt_q    <= '0;
         state_q   <= IDLE;
         wcnt_q    <= '0;
         b1_q      <= 1'b0;
         b2_q      <= 1'b0;
      end else begin
         meta_q    <= meta_d;
         sync_q    <= sync_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         dcnt_q    <= dcnt_d;
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         b1_q      <= b1_d;
         b2_q      <= b2_d;
      end
   end

   assign b1 = b1_q;
   assign b2 = b2_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: directed scenarios plus random button traffic, each
// segment checked cycle by cycle against a press-event model of the button stage.
module tb_condicionador_botoes;

   localparam int D    = 4;
   localparam int CW   = 8;
   localparam int MAXN = 400;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn1_in = 1'b1;
   logic btn2_in = 1'b1;
   logic b1, b2;

   int n_cmp = 0;
   int n_bad = 0;

   // stimulus as pressed levels per cycle, captured outputs, model results
   bit in1 [MAXN];
   bit in2 [MAXN];
   bit ob1 [MAXN];
   bit ob2 [MAXN];
   bit e1  [MAXN];
   bit e2  [MAXN];
   bit md1 [MAXN+1];
   bit md2 [MAXN+1];

   condicionador_botoes #(
      .DEBOUNCE_CYCLES(D),
      .COMBO_WINDOW   (CW),
      .BTN_ACTIVE_LOW (1)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn1_in(btn1_in),
      .btn2_in(btn2_in),
      .b1     (b1),
      .b2     (b2)
   );

   always #5 clk = ~clk;

   task automatic clear_stim();
      for (int k = 0; k < MAXN; k++) begin
         in1[k] = 1'b0;
         in2[k] = 1'b0;
      end
   endtask

   // Reset with pins released, then run n cycles; cycle k starts just after a rising edge.
   task automatic run_seg(input int n);
      rst_n   = 1'b0;
      btn1_in = 1'b1;
      btn2_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         ob1[k]  = b1;
         ob2[k]  = b2;
         btn1_in = ~in1[k];
         btn2_in = ~in2[k];
      end
   endtask

   function automatic bit synced(input int b, input int k);
      if (k < 2) return 1'b0;
      return (b == 1) ? in1[k-2] : in2[k-2];
   endfunction

   // Debounced level flips once the synced level has disagreed with it for D straight cycles.
   // A press is a cycle where the debounced level is newly high. A first press opens a window
   // of CW cycles for the other press; the command lands the cycle after the decision, and
   // everything is then ignored until both debounced levels are low.
   task automatic build_model(input int n);
      md1[0] = 1'b0;
      md2[0] = 1'b0;
      for (int k = 0; k < n; k++) begin
         bit all1, all2;
         all1 = 1'b1;
         all2 = 1'b1;
         for (int j = 0; j < D; j++) begin
            if (synced(1, k - j) == md1[k]) all1 = 1'b0;
            if (synced(2, k - j) == md2[k]) all2 = 1'b0;
         end
         md1[k+1] = all1 ? ~md1[k] : md1[k];
         md2[k+1] = all2 ? ~md2[k] : md2[k];
         e1[k] = 1'b0;
         e2[k] = 1'b0;
      end
      begin
         int t;
         t = 0;
         while (t < n) begin
            bit p1, p2;
            p1 = md1[t] && !(t > 0 && md1[t-1]);
            p2 = md2[t] && !(t > 0 && md2[t-1]);
            if (p1 || p2) begin
               int  e, c;
               bit  combo;
               combo = p1 && p2;
               e = t + CW;
               if (!combo) begin
                  for (int q = t + 1; q <= t + CW; q++) begin
                     if (q < n && !combo) begin
                        bit other;
                        other = p1 ? (md2[q] && !md2[q-1]) : (md1[q] && !md1[q-1]);
                        if (other) begin
                           combo = 1'b1;
                           e = q;
                        end
                     end
                  end
               end else begin
                  e = t;
               end
               if (e + 1 < n) begin
                  e1[e+1] = combo || p1;
                  e2[e+1] = combo || p2;
               end
               c = e + 1;
               while (c < n && (md1[c] || md2[c])) c++;
               t = c + 1;
            end else begin
               t++;
            end
         end
      end
   endtask

   task automatic test_reset();
      clear_stim();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({b1, b2} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_hold: b1b2=%b%b required 00", b1, b2);
      end
      run_seg(50);
      build_model(50);
      for (int k = 0; k < 50; k++) begin
         n_cmp++;
         if ({ob1[k], ob2[k]} !== 2'b00 || {ob1[k], ob2[k]} !== {e1[k], e2[k]}) begin
            n_bad++;
            $display("FAIL reset_idle cycle %0d: b1b2=%b%b required %b%b", k, ob1[k], ob2[k], e1[k], e2[k]);
         end
      end
   endtask

   task automatic test_single_press();
      int c1, c2;
      clear_stim();
      for (int k = 5; k < 45; k++) in1[k] = 1'b1;
      for (int k = 60; k < 90; k++) in1[k] = 1'b1;
      run_seg(120);
      build_model(120);
      c1 = 0;
      c2 = 0;
      for (int k = 0; k < 120; k++) begin
         c1 += int'(ob1[k]);
         c2 += int'(ob2[k]);
         n_cmp++;
         if ({ob1[k], ob2[k]} !== {e1[k], e2[k]}) begin
            n_bad++;
            $display("FAIL single cycle %0d: b1b2=%b%b required %b%b", k, ob1[k], ob2[k], e1[k], e2[k]);
         end
      end
      // press edge at 5+2+D = 11, pulse CW+1 later; re-press at 60 -> edge 66, pulse 75
      n_cmp++;
      if (ob1[20] !== 1'b1 || ob1[75] !== 1'b1 || c1 != 2 || c2 != 0) begin
         n_bad++;
         $display("FAIL single_timing: b1@20=%b b1@75=%b b1_count=%0d b2_count=%0d required 1 1 2 0",
                  ob1[20], ob1[75], c1, c2);
      end
   endtask

   task automatic test_combo();
      int c1, c2;
      clear_stim();
      for (int k = 5; k < 50; k++) in1[k] = 1'b1;
      for (int k = 10; k < 50; k++) in2[k] = 1'b1;
      run_seg(80);
      build_model(80);
      c1 = 0;
      c2 = 0;
      for (int k = 0; k < 80; k++) begin
         c1 += int'(ob1[k]);
         c2 += int'(ob2[k]);
         n_cmp++;
         if ({ob1[k], ob2[k]} !== {e1[k], e2[k]}) begin
            n_bad++;
            $display("FAIL combo cycle %0d: b1b2=%b%b required %b%b", k, ob1[k], ob2[k], e1[k], e2[k]);
         end
      end
      n_cmp++;
      if ({ob1[17], ob2[17]} !== 2'b11 || c1 != 1 || c2 != 1) begin
         n_bad++;
         $display("FAIL combo_timing: b1b2@17=%b%b counts=%0d/%0d required 11 1/1", ob1[17], ob2[17], c1, c2);
      end
   endtask

   task automatic test_window_edge();
      for (int gap = CW; gap <= CW + 1; gap++) begin
         int c1, c2;
         clear_stim();
         for (int k = 5; k < 60; k++) in1[k] = 1'b1;
         for (int k = 5 + gap; k < 60; k++) in2[k] = 1'b1;
         run_seg(100);
         build_model(100);
         c1 = 0;
         c2 = 0;
         for (int k = 0; k < 100; k++) begin
            c1 += int'(ob1[k]);
            c2 += int'(ob2[k]);
            n_cmp++;
            if ({ob1[k], ob2[k]} !== {e1[k], e2[k]}) begin
               n_bad++;
               $display("FAIL window_gap%0d cycle %0d: b1b2=%b%b required %b%b",
                        gap, k, ob1[k], ob2[k], e1[k], e2[k]);
            end
         end
         n_cmp++;
         if (ob1[20] !== 1'b1 || c1 != 1 || c2 != ((gap == CW) ? 1 : 0) ||
             ob2[20] !== ((gap == CW) ? 1'b1 : 1'b0)) begin
            n_bad++;
            $display("FAIL window_gap%0d_result: b1b2@20=%b%b counts=%0d/%0d", gap, ob1[20], ob2[20], c1, c2);
         end
      end
   endtask

   task automatic test_debounce();
      int c1;
      clear_stim();
      for (int k = 5; k < 8; k++) in1[k] = 1'b1;
      in1[20] = 1'b1;
      in1[22] = 1'b1;
      for (int k = 24; k < 60; k++) in1[k] = 1'b1;
      run_seg(90);
      build_model(90);
      c1 = 0;
      for (int k = 0; k < 90; k++) begin
         c1 += int'(ob1[k]);
         n_cmp++;
         if ({ob1[k], ob2[k]} !== {e1[k], e2[k]}) begin
            n_bad++;
            $display("FAIL debounce cycle %0d: b1b2=%b%b required %b%b", k, ob1[k], ob2[k], e1[k], e2[k]);
         end
      end
      // steady from 24 -> edge at 30 -> pulse at 39; the 3-cycle glitch gives nothing
      n_cmp++;
      if (ob1[39] !== 1'b1 || c1 != 1) begin
         n_bad++;
         $display("FAIL debounce_result: b1@39=%b b1_count=%0d required 1 1", ob1[39], c1);
      end
   endtask

   task automatic test_reset_mid_window();
      clear_stim();
      for (int k = 5; k < MAXN; k++) in1[k] = 1'b1;
      // edge at 11, WAIT1 from 12, wcnt reaches 4 in cycle 16
      run_seg(17);
      for (int k = 0; k < 17; k++) begin
         n_cmp++;
         if ({ob1[k], ob2[k]} !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_window_pre cycle %0d: b1b2=%b%b required 00", k, ob1[k], ob2[k]);
         end
      end
      clear_stim();
      run_seg(40);
      build_model(40);
      for (int k = 0; k < 40; k++) begin
         n_cmp++;
         if ({ob1[k], ob2[k]} !== 2'b00 || {ob1[k], ob2[k]} !== {e1[k], e2[k]}) begin
            n_bad++;
            $display("FAIL mid_window_post cycle %0d: b1b2=%b%b required 00", k, ob1[k], ob2[k]);
         end
      end
   endtask

   task automatic test_random();
      for (int seg = 0; seg < 30; seg++) begin
         int n;
         n = 300;
         clear_stim();
         for (int b = 1; b <= 2; b++) begin
            int k;
            bit lvl;
            k = 0;
            lvl = 1'b0;
            while (k < n) begin
               int len;
               len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 30));
               for (int j = 0; j < len && k < n; j++) begin
                  if (b == 1) in1[k] = lvl;
                  else        in2[k] = lvl;
                  k++;
               end
               lvl = ~lvl;
            end
         end
         // half the segments: button 2 shadows button 1 with a small lag, to hit the window
         if (seg % 2 == 1) begin
            int lag;
            lag = int'($urandom_range(0, 12));
            for (int k = 0; k < n; k++) in2[k] = (k >= lag) ? in1[k-lag] : 1'b0;
         end
         run_seg(n);
         build_model(n);
         for (int k = 0; k < n; k++) begin
            n_cmp++;
            if ({ob1[k], ob2[k]} !== {e1[k], e2[k]}) begin
               n_bad++;
               $display("FAIL random seg %0d cycle %0d: b1b2=%b%b required %b%b",
                        seg, k, ob1[k], ob2[k], e1[k], e2[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_combo();
      test_window_edge();
      test_debounce();
      test_reset_mid_window();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
